sram_like_resp: RTL and testbench

SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

---
 rtl/sram_like_resp_pkg.sv | 24 ++
 rtl/sram_like_resp_if.sv | 26 ++
 rtl/sram_resp_fifo.sv | 54 +++++
 rtl/sram_like_resp.sv | 138 +++++++++++++
 tb/tb_sram_like_resp.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_resp_pkg.sv
// Shared types and constants for the SRAM-like responder: FSM states, access sizes, LFSR seed.
package sram_like_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_like_resp_if.sv
// CPU-side request/response bus plus backend RAM port of the SRAM-like responder.
interface sram_like_resp_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport master (
    output req, wr, size, addr, wdata, ram_rdata,
    input  addr_ok, data_ok, rdata, ram_en, ram_wen, ram_addr, ram_wdata
  );

  modport slave (
    input  req, wr, size, addr, wdata, ram_rdata,
    output addr_ok, data_ok, rdata, ram_en, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/sram_resp_fifo.sv
// Outstanding-request queue: DEPTH entries (power of two), head visible on dout.
module sram_resp_fifo #(
  parameter  int WIDTH = 67,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like responder: queues CPU requests, issues them to a 1-cycle-latency RAM in order.
// Optional build macro SRAM_RESP_RAND_DELAY_EN adds LFSR-driven accept gating and extra wait.
//
// state    | meaning
// ST_IDLE  | waiting for a queued request
// ST_WAIT  | counting down the fixed (plus random) access delay
// ST_ISSUE | ram_en strobe with the head entry
// ST_RESP  | data_ok pulse, head popped
module sram_like_resp
  import sram_like_resp_pkg::*;
#(
  parameter int DELAY = 0,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  sram_like_resp_if.slave  bus
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int CNTW = 5;

  req_t            in_req;
  req_t            head;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            accept_gate;
  logic [CNTW-1:0] wait_cnt;

  state_t          state;
  state_t          state_nx;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nx;
  logic            issue;
  logic            resp;
  logic [3:0]      wen_dec;

`ifdef SRAM_RESP_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign accept_gate = lfsr[0];
  assign wait_cnt    = CNTW'(DELAY) + CNTW'(lfsr[2:1]);
`else
  assign accept_gate = 1'b1;
  assign wait_cnt    = CNTW'(DELAY);
`endif

  assign in_req = {bus.wr, bus.size, bus.addr, bus.wdata};
  // addr_ok depends only on registered state, never on req or this cycle's pop
  assign bus.addr_ok = !rst && !full && accept_gate;
  assign push        = bus.req && bus.addr_ok;
  assign pop         = resp && (count != '0);

  sram_resp_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_req),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    issue    = 1'b0;
    resp     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          if (wait_cnt != '0) begin
            state_nx = ST_WAIT;
            cnt_nx   = wait_cnt;
          end else begin
            state_nx = ST_ISSUE;
          end
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= CNTW'(1)) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        issue    = 1'b1;
        state_nx = ST_RESP;
      end
      ST_RESP: begin
        resp     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Misaligned half/word accesses simply ignore the extra low address bits
  always_comb begin
    wen_dec = 4'b0000;
    if (head.wr) begin
      case (head.size)
        SZ_BYTE: wen_dec = 4'b0001 << head.addr[1:0];
        SZ_HALF: wen_dec = 4'b0011 << {head.addr[1], 1'b0};
        default: wen_dec = 4'b1111;
      endcase
    end
  end

  assign bus.ram_en    = !rst && issue;
  assign bus.ram_wen   = bus.ram_en ? wen_dec : 4'b0000;
  assign bus.ram_addr  = {head.addr[31:2], 2'b00};
  assign bus.ram_wdata = head.wdata;
  assign bus.data_ok   = !rst && resp;
  assign bus.rdata     = bus.ram_rdata;

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: DELAY=0 and DELAY=3 instances, queue-based completion model plus pinned literals.
module tb_sram_like_resp;
  import sram_like_resp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int tmo = 0;
  bit fin_req = 1'b0;
  bit fin_done = 1'b0;

  int          sel = 0;
  logic        s_req = 1'b0;
  logic        s_wr = 1'b0;
  logic [1:0]  s_size = 2'd0;
  logic [31:0] s_addr = '0;
  logic [31:0] s_wdata = '0;

  sram_like_resp_if bus0 ();
  sram_like_resp_if bus1 ();

  sram_like_resp #(.DELAY(0), .DEPTH(2)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  sram_like_resp #(.DELAY(3), .DEPTH(2)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  logic        aok [2];
  logic        dok [2];
  logic        ren [2];
  logic        rqv [2];
  logic [3:0]  wen [2];
  logic [31:0] raddr [2];
  logic [31:0] rdat [2];
  logic [31:0] wdat [2];
  logic [31:0] rdq [2];

  assign bus0.req = s_req && (sel == 0);
  assign bus1.req = s_req && (sel == 1);
  assign {bus0.wr, bus0.size, bus0.addr, bus0.wdata} = {s_wr, s_size, s_addr, s_wdata};
  assign {bus1.wr, bus1.size, bus1.addr, bus1.wdata} = {s_wr, s_size, s_addr, s_wdata};
  assign bus0.ram_rdata = rdq[0];
  assign bus1.ram_rdata = rdq[1];
  assign {rqv[0], aok[0], dok[0], ren[0], wen[0]} = {bus0.req, bus0.addr_ok, bus0.data_ok, bus0.ram_en, bus0.ram_wen};
  assign {rqv[1], aok[1], dok[1], ren[1], wen[1]} = {bus1.req, bus1.addr_ok, bus1.data_ok, bus1.ram_en, bus1.ram_wen};
  assign {raddr[0], rdat[0], wdat[0]} = {bus0.ram_addr, bus0.rdata, bus0.ram_wdata};
  assign {raddr[1], rdat[1], wdat[1]} = {bus1.ram_addr, bus1.rdata, bus1.ram_wdata};

  function automatic logic [31:0] pat(input int k, input int i);
    if (i == 'h40) return 32'hDEADBEEF;
    return {16'hC0DE, 8'(k), 8'(i)};
  endfunction

  function automatic int dly(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Backend RAM: one-cycle read latency, byte-lane writes
  logic [31:0] ram [2][256];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 256; i++) ram[k][i] <= pat(k, i);
      mem_init <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ren[k]) begin
          for (int b = 0; b < 4; b++)
            if (wen[k][b]) ram[k][raddr[k][9:2]][8*b +: 8] <= wdat[k][8*b +: 8];
          rdq[k] <= ram[k][raddr[k][9:2]];
        end
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          due;
  } mreq_t;

  typedef struct {
    int          k;
    int          at;
    int          what;
    logic [31:0] val;
  } pin_t;

  localparam int P_AOK = 0, P_DOK = 1, P_REN = 2, P_WEN = 3, P_RADDR = 4, P_RDATA = 5;
  pin_t pins [256];
  int   npins = 0;
  int   pin_hit = 0;

  mreq_t       mq [2][$];
  int          last_done [2];
  logic [31:0] refm [2][256];
  bit          ref_init = 1'b0;

  function automatic logic [3:0] exp_wen(input mreq_t r);
    if (!r.wr) return 4'b0000;
    if (r.size == SZ_BYTE) begin
      case (r.addr[1:0])
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (r.size == SZ_HALF) return r.addr[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] probe(input int k, input int what);
    case (what)
      P_AOK:   return {31'd0, aok[k]};
      P_DOK:   return {31'd0, dok[k]};
      P_REN:   return {31'd0, ren[k]};
      P_WEN:   return {28'd0, wen[k]};
      P_RADDR: return raddr[k];
      default: return rdat[k];
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Single compare process: model-driven per-cycle checks plus pinned literals
  always @(negedge clk) begin
    if (!ref_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 256; i++) refm[k][i] = pat(k, i);
      last_done[0] = -100;
      last_done[1] = -100;
      ref_init = 1'b1;
    end
    for (int i = 0; i < npins; i++) begin
      if (pins[i].at == cyc) begin
        pin_hit++;
        chk($sformatf("pin_k%0d_sig%0d", pins[i].k, pins[i].what), probe(pins[i].k, pins[i].what), pins[i].val);
      end
    end
    for (int k = 0; k < 2; k++) begin
      int    outst;
      bit    exp_en;
      bit    exp_ok;
      mreq_t r;
      logic [3:0] ew;
      if (rst) begin
        chk($sformatf("rst_addr_ok%0d", k), {31'd0, aok[k]}, 32'd0);
        chk($sformatf("rst_data_ok%0d", k), {31'd0, dok[k]}, 32'd0);
        chk($sformatf("rst_ram_en%0d", k), {31'd0, ren[k]}, 32'd0);
        chk($sformatf("rst_ram_wen%0d", k), {28'd0, wen[k]}, 32'd0);
        mq[k].delete();
        last_done[k] = -100;
        continue;
      end
      outst  = mq[k].size();
      exp_en = 1'b0;
      exp_ok = 1'b0;
`ifdef SRAM_RESP_RAND_DELAY_EN
      if (aok[k] && outst >= 2) chk($sformatf("addr_ok_full%0d", k), {31'd0, aok[k]}, 32'd0);
      if ((ren[k] || dok[k]) && outst == 0) chk($sformatf("spurious%0d", k), {31'd0, ren[k] | dok[k]}, 32'd0);
      exp_en = ren[k] && outst > 0;
      exp_ok = dok[k] && outst > 0;
`else
      if (outst > 0) begin
        exp_en = (mq[k][0].due == cyc);
        exp_ok = (mq[k][0].due + 1 == cyc);
      end
      chk($sformatf("addr_ok%0d", k), {31'd0, aok[k]}, {31'd0, outst < 2});
      chk($sformatf("ram_en%0d", k), {31'd0, ren[k]}, {31'd0, exp_en});
      chk($sformatf("data_ok%0d", k), {31'd0, dok[k]}, {31'd0, exp_ok});
`endif
      if (exp_en) begin
        r  = mq[k][0];
        ew = exp_wen(r);
        chk($sformatf("ram_addr%0d", k), raddr[k], {r.addr[31:2], 2'b00});
        chk($sformatf("ram_wen%0d", k), {28'd0, wen[k]}, {28'd0, ew});
        chk($sformatf("ram_wdata%0d", k), wdat[k], r.wdata);
      end
      if (exp_ok) begin
        r  = mq[k].pop_front();
        ew = exp_wen(r);
        if (!r.wr) chk($sformatf("rdata%0d", k), rdat[k], refm[k][r.addr[9:2]]);
        for (int b = 0; b < 4; b++)
          if (ew[b]) refm[k][r.addr[9:2]][8*b +: 8] = r.wdata[8*b +: 8];
      end
      if (rqv[k] && aok[k]) begin
        int c;
        c = (cyc + 1 > last_done[k] + 1) ? cyc + 1 : last_done[k] + 1;
        r = '{wr: s_wr, size: s_size, addr: s_addr, wdata: s_wdata, due: c + dly(k) + 1};
        last_done[k] = r.due + 1;
        mq[k].push_back(r);
      end
    end
    if (fin_req && !fin_done) begin
      chk("drain0", mq[0].size(), 32'd0);
      chk("drain1", mq[1].size(), 32'd0);
      chk("timeouts", tmo, 32'd0);
`ifndef SRAM_RESP_RAND_DELAY_EN
      chk("pins_hit", pin_hit, npins);
`endif
      fin_done = 1'b1;
    end
  end

  task automatic add_pin(input int k, input int at, input int what, input logic [31:0] val);
`ifndef SRAM_RESP_RAND_DELAY_EN
    pins[npins] = '{k: k, at: at, what: what, val: val};
    npins++;
`endif
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the request until accepted; leaves req high so callers can chain requests
  task automatic do_req(input int k, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, output int t);
    sel = k; s_req = 1'b1; s_wr = w; s_size = sz; s_addr = a; s_wdata = d;
    t = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (aok[k]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      tmo++;
      $display("FAIL accept_timeout k=%0d addr=%h", k, a);
    end
    step(1);
  endtask

  initial begin
    int t, t2, tb;
    step(1);
    for (int k = 0; k < 2; k++) begin
      add_pin(k, cyc, P_AOK, 0);
      add_pin(k, cyc, P_DOK, 0);
      add_pin(k, cyc, P_REN, 0);
    end
    step(1);
    rst = 1'b0;
    add_pin(0, cyc, P_AOK, 1);
    add_pin(1, cyc, P_AOK, 1);
    step(2);

    // single load, DELAY=0
    do_req(0, 1'b0, SZ_WORD, 32'h100, 32'h0, t);
    s_req = 1'b0;
    add_pin(0, t + 1, P_REN, 0);
    add_pin(0, t + 2, P_REN, 1);
    add_pin(0, t + 2, P_RADDR, 32'h100);
    add_pin(0, t + 2, P_WEN, 0);
    add_pin(0, t + 3, P_DOK, 1);
    add_pin(0, t + 3, P_RDATA, 32'hDEADBEEF);
    step(6);

    // byte and half stores, then read back the merged word
    do_req(0, 1'b1, SZ_BYTE, 32'h203, 32'h11000000, t);
    s_req = 1'b0;
    add_pin(0, t + 2, P_WEN, 4'b1000);
    add_pin(0, t + 2, P_RADDR, 32'h200);
    add_pin(0, t + 3, P_DOK, 1);
    add_pin(0, t + 4, P_DOK, 0);
    step(5);
    do_req(0, 1'b1, SZ_HALF, 32'h202, 32'h22330000, t);
    s_req = 1'b0;
    add_pin(0, t + 2, P_WEN, 4'b1100);
    step(5);
    do_req(0, 1'b0, SZ_WORD, 32'h200, 32'h0, t);
    s_req = 1'b0;
    add_pin(0, t + 3, P_RDATA, 32'h22330080);
    step(6);

    // four loads with req held high into a 2-deep queue
    do_req(0, 1'b0, SZ_WORD, 32'h000, 32'h0, tb);
    add_pin(0, tb + 2, P_AOK, 0);
    add_pin(0, tb + 3, P_AOK, 0);
    add_pin(0, tb + 4, P_AOK, 1);
    add_pin(0, tb + 3, P_DOK, 1);
    add_pin(0, tb + 3, P_RDATA, 32'hC0DE0000);
    add_pin(0, tb + 5, P_DOK, 0);
    add_pin(0, tb + 6, P_DOK, 1);
    add_pin(0, tb + 6, P_RDATA, 32'hC0DE0001);
    add_pin(0, tb + 9, P_DOK, 1);
    add_pin(0, tb + 9, P_RDATA, 32'hC0DE0002);
    add_pin(0, tb + 12, P_DOK, 1);
    add_pin(0, tb + 12, P_RDATA, 32'hC0DE0003);
    do_req(0, 1'b0, SZ_WORD, 32'h004, 32'h0, t);
    do_req(0, 1'b0, SZ_WORD, 32'h008, 32'h0, t);
    do_req(0, 1'b0, SZ_WORD, 32'h00C, 32'h0, t);
    s_req = 1'b0;
    step(10);

    // DELAY=3 single load
    do_req(1, 1'b0, SZ_WORD, 32'h100, 32'h0, t);
    s_req = 1'b0;
    add_pin(1, t + 4, P_REN, 0);
    add_pin(1, t + 5, P_REN, 1);
    add_pin(1, t + 5, P_DOK, 0);
    add_pin(1, t + 6, P_DOK, 1);
    add_pin(1, t + 6, P_RDATA, 32'hDEADBEEF);
    step(10);

    // reset while waiting with two entries queued
    do_req(1, 1'b0, SZ_WORD, 32'h010, 32'h0, t);
    do_req(1, 1'b0, SZ_WORD, 32'h014, 32'h0, t2);
    s_req = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    add_pin(1, cyc, P_AOK, 1);
    for (int n = 0; n < 20; n++) begin
      add_pin(1, cyc + n, P_REN, 0);
      add_pin(1, cyc + n, P_DOK, 0);
    end
    step(22);

    // random traffic on both instances against the reference memory
    for (int i = 0; i < 1000; i++) begin
      do_req((i / 50) % 2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             32'($urandom_range(0, 1023)), $urandom, t);
      if ($urandom_range(0, 3) == 0) begin
        s_req = 1'b0;
        step($urandom_range(1, 4));
      end
    end
    s_req = 1'b0;
    step(60);

    fin_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
